// File: rtl/alu_operand_stage.sv
// Registered ALU operand-select stage: forwarding, load-use stall,
// valid/ready handshake and a saturating stall counter.
module alu_operand_stage #(
  parameter int WIDTH  = 32,
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  ReadData1,
  input  logic [WIDTH-1:0]  ReadData2,
  input  logic [WIDTH-1:0]  SignExtend,
  input  logic [4:0]        Shamt,
  input  logic [1:0]        ALUSrc,
  input  logic [REG_AW-1:0] RsAddr,
  input  logic [REG_AW-1:0] RtAddr,
  input  logic              ExMemRegWrite,
  input  logic              ExMemIsLoad,
  input  logic [REG_AW-1:0] ExMemRd,
  input  logic [WIDTH-1:0]  ExMemResult,
  input  logic              MemWbRegWrite,
  input  logic [REG_AW-1:0] MemWbRd,
  input  logic [WIDTH-1:0]  MemWbResult,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  ALU1,
  output logic [WIDTH-1:0]  ALU2,
  output logic [1:0]        FwdA,
  output logic [1:0]        FwdB,
  output logic              HazardStall,
  output logic [CNT_W-1:0]  StallCount
);

  logic             ex_a, wb_a, ex_b, wb_b, cap;
  logic [WIDTH-1:0] a_sel, b_sel, upper, shamt_ext;
  logic [1:0]       fa_sel, fb_sel;

  assign ex_a = ExMemRegWrite && (ExMemRd != '0)
              && (ExMemRd == RsAddr);
  assign wb_a = MemWbRegWrite && (MemWbRd != '0)
              && (MemWbRd == RsAddr);
  assign ex_b = ExMemRegWrite && (ExMemRd != '0)
              && (ExMemRd == RtAddr);
  assign wb_b = MemWbRegWrite && (MemWbRd != '0)
              && (MemWbRd == RtAddr);

  assign upper     = WIDTH'(SignExtend[15:0]) << (WIDTH - 16);
  assign shamt_ext = WIDTH'(Shamt);

  assign HazardStall = in_valid && ExMemIsLoad
                     && (ex_a || ((ALUSrc == 2'b00) && ex_b));
  assign in_ready = (!out_valid || out_ready) && !HazardStall;
  assign cap      = in_valid && in_ready;

  // EX/MEM wins over MEM/WB: it holds the younger result
  always_comb begin
    a_sel  = ReadData1;
    fa_sel = 2'b00;
    if (ex_a) begin
      a_sel  = ExMemResult;
      fa_sel = 2'b10;
    end else if (wb_a) begin
      a_sel  = MemWbResult;
      fa_sel = 2'b01;
    end
  end

  always_comb begin
    b_sel  = ReadData2;
    fb_sel = 2'b00;
    unique case (ALUSrc)
      2'b00: begin
        if (ex_b) begin
          b_sel  = ExMemResult;
          fb_sel = 2'b10;
        end else if (wb_b) begin
          b_sel  = MemWbResult;
          fb_sel = 2'b01;
        end
      end
      2'b01: b_sel = SignExtend;
      2'b10: b_sel = upper;
      2'b11: b_sel = shamt_ext;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      ALU1      <= '0;
      ALU2      <= '0;
      FwdA      <= 2'b00;
      FwdB      <= 2'b00;
    end else if (cap) begin
      out_valid <= 1'b1;
      ALU1      <= a_sel;
      ALU2      <= b_sel;
      FwdA      <= fa_sel;
      FwdB      <= fb_sel;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset)
      StallCount <= '0;
    else if (HazardStall && (StallCount != {CNT_W{1'b1}}))
      StallCount <= StallCount + 1'b1;
  end

endmodule

// File: tb/tb_alu_operand_stage.sv
// Self-checking bench for alu_operand_stage against a
// behavioural model of the operand-select rules.
module tb_alu_operand_stage;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] ReadData1, ReadData2, SignExtend;
  logic [4:0]   Shamt;
  logic [1:0]   ALUSrc;
  logic [4:0]   RsAddr, RtAddr;
  logic         ExMemRegWrite, ExMemIsLoad;
  logic [4:0]   ExMemRd;
  logic [W-1:0] ExMemResult;
  logic         MemWbRegWrite;
  logic [4:0]   MemWbRd;
  logic [W-1:0] MemWbResult;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] ALU1, ALU2;
  logic [1:0]   FwdA, FwdB;
  logic         HazardStall;
  logic [2:0]   StallCount;

  int checks = 0;
  int errors = 0;

  // model state
  bit           m_valid;
  bit [W-1:0]   m_a, m_b;
  bit [1:0]     m_fa, m_fb;
  int           m_cnt;

  always #5 clk = ~clk;

  alu_operand_stage #(.WIDTH(W), .REG_AW(5), .CNT_W(3)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .ReadData1(ReadData1), .ReadData2(ReadData2),
    .SignExtend(SignExtend), .Shamt(Shamt), .ALUSrc(ALUSrc),
    .RsAddr(RsAddr), .RtAddr(RtAddr),
    .ExMemRegWrite(ExMemRegWrite), .ExMemIsLoad(ExMemIsLoad),
    .ExMemRd(ExMemRd), .ExMemResult(ExMemResult),
    .MemWbRegWrite(MemWbRegWrite), .MemWbRd(MemWbRd),
    .MemWbResult(MemWbResult),
    .out_valid(out_valid), .out_ready(out_ready),
    .ALU1(ALU1), .ALU2(ALU2), .FwdA(FwdA), .FwdB(FwdB),
    .HazardStall(HazardStall), .StallCount(StallCount)
  );

  function automatic bit exm(bit [4:0] x);
    return ExMemRegWrite && ExMemRd != 0 && ExMemRd == x;
  endfunction

  function automatic bit wbm(bit [4:0] x);
    return MemWbRegWrite && MemWbRd != 0 && MemWbRd == x;
  endfunction

  function automatic bit m_hz();
    return in_valid && ExMemIsLoad
      && (exm(RsAddr) || (ALUSrc == 0 && exm(RtAddr)));
  endfunction

  function automatic bit m_rdy();
    return (!m_valid || out_ready) && !m_hz();
  endfunction

  // advance the model by one clock and wait the edge
  task automatic cycle();
    bit hz, rdy;
    hz  = m_hz();
    rdy = m_rdy();
    if (reset) begin
      m_valid = 0; m_a = 0; m_b = 0; m_fa = 0; m_fb = 0;
      m_cnt = 0;
    end else begin
      if (in_valid && rdy) begin
        m_valid = 1;
        if (exm(RsAddr)) begin
          m_a = ExMemResult; m_fa = 2;
        end else if (wbm(RsAddr)) begin
          m_a = MemWbResult; m_fa = 1;
        end else begin
          m_a = ReadData1; m_fa = 0;
        end
        m_fb = 0;
        case (ALUSrc)
          0: if (exm(RtAddr)) begin
               m_b = ExMemResult; m_fb = 2;
             end else if (wbm(RtAddr)) begin
               m_b = MemWbResult; m_fb = 1;
             end else m_b = ReadData2;
          1: m_b = SignExtend;
          2: m_b = SignExtend[15:0] * 32'h10000;
          default: m_b = Shamt;
        endcase
      end else if (out_ready) begin
        m_valid = 0;
      end
      if (hz && m_cnt < 7) m_cnt++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    reset = 0; in_valid = 0; out_ready = 1;
    ReadData1 = 0; ReadData2 = 0; SignExtend = 0;
    Shamt = 0; ALUSrc = 0; RsAddr = 0; RtAddr = 0;
    ExMemRegWrite = 0; ExMemIsLoad = 0; ExMemRd = 0;
    ExMemResult = 0; MemWbRegWrite = 0; MemWbRd = 0;
    MemWbResult = 0;
  endtask

  task automatic rand_ops();
    ReadData1   = $urandom; ReadData2 = $urandom;
    SignExtend  = $urandom; Shamt = 5'($urandom);
    ALUSrc      = 2'($urandom);
    RsAddr      = 5'($urandom_range(0, 3));
    RtAddr      = 5'($urandom_range(0, 3));
    ExMemRegWrite = 1'($urandom); MemWbRegWrite = 1'($urandom);
    ExMemRd     = 5'($urandom_range(0, 3));
    MemWbRd     = 5'($urandom_range(0, 3));
    ExMemResult = $urandom; MemWbResult = $urandom;
  endtask

  task automatic test_reset();
    quiet();
    in_valid = 1; reset = 1;
    ReadData1 = 32'h1234; ReadData2 = 32'h5678;
    cycle();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_valid got %b want 0", out_valid);
    end
    checks++;
    if (ALU1 !== 0 || ALU2 !== 0) begin
      errors++;
      $display("FAIL reset_data got %h/%h want 0/0", ALU1, ALU2);
    end
    checks++;
    if (StallCount !== 0 || FwdA !== 0 || FwdB !== 0) begin
      errors++;
      $display("FAIL reset_misc cnt %0d fa %b fb %b want 0",
               StallCount, FwdA, FwdB);
    end
  endtask

  task automatic test_alusrc();
    logic [W-1:0] exp [4];
    exp = '{32'h11, 32'hFFFF8001, 32'h80010000, 32'h7};
    quiet();
    in_valid = 1; ReadData2 = 32'h11;
    SignExtend = 32'hFFFF8001; Shamt = 5'd7;
    for (int s = 0; s < 4; s++) begin
      ALUSrc = 2'(s);
      cycle();
      checks++;
      if (ALU2 !== exp[s] || out_valid !== 1'b1) begin
        errors++;
        $display("FAIL alusrc%0d ALU2 %h v %b want %h v 1",
                 s, ALU2, out_valid, exp[s]);
      end
    end
  endtask

  task automatic test_forwarding();
    quiet();
    in_valid = 1; RsAddr = 3; RtAddr = 3;
    ExMemRd = 3; MemWbRd = 3;
    ExMemRegWrite = 1; MemWbRegWrite = 1;
    ExMemResult = 32'hAA; MemWbResult = 32'hBB;
    ReadData1 = 32'h1111; ReadData2 = 32'h2222;
    cycle();
    checks++;
    if (ALU1 !== 32'hAA || ALU2 !== 32'hAA
        || FwdA !== 2'b10 || FwdB !== 2'b10) begin
      errors++;
      $display("FAIL fwd_ex got %h %h %b %b want aa aa 10 10",
               ALU1, ALU2, FwdA, FwdB);
    end
    ExMemRegWrite = 0;
    cycle();
    checks++;
    if (ALU1 !== 32'hBB || ALU2 !== 32'hBB
        || FwdA !== 2'b01 || FwdB !== 2'b01) begin
      errors++;
      $display("FAIL fwd_wb got %h %h %b %b want bb bb 01 01",
               ALU1, ALU2, FwdA, FwdB);
    end
    ExMemRegWrite = 1; ExMemRd = 0; MemWbRd = 0;
    cycle();
    checks++;
    if (ALU1 !== 32'h1111 || ALU2 !== 32'h2222
        || FwdA !== 2'b00 || FwdB !== 2'b00) begin
      errors++;
      $display("FAIL fwd_r0 got %h %h %b %b want 1111 2222 00 00",
               ALU1, ALU2, FwdA, FwdB);
    end
  endtask

  task automatic test_load_use();
    quiet();
    reset = 1;
    cycle();
    reset = 0; in_valid = 1;
    ExMemIsLoad = 1; ExMemRegWrite = 1; ExMemRd = 4;
    RsAddr = 4; RtAddr = 9; ExMemResult = 32'hCAFE;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (HazardStall !== 1'b1 || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL lu_stall%0d hz %b rdy %b want 1 0",
                 i, HazardStall, in_ready);
      end
      cycle();
    end
    checks++;
    if (StallCount !== 3'd3 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL lu_count cnt %0d v %b want 3 0",
               StallCount, out_valid);
    end
    ExMemIsLoad = 0;
    cycle();
    checks++;
    if (out_valid !== 1'b1 || ALU1 !== 32'hCAFE
        || FwdA !== 2'b10) begin
      errors++;
      $display("FAIL lu_release v %b a %h fa %b want 1 cafe 10",
               out_valid, ALU1, FwdA);
    end
  endtask

  task automatic test_backpressure();
    logic [W-1:0] ha, hb;
    quiet();
    in_valid = 1; ReadData1 = 32'h55; ReadData2 = 32'h66;
    cycle();
    ha = ALU1; hb = ALU2;
    checks++;
    if (ha !== 32'h55 || hb !== 32'h66) begin
      errors++;
      $display("FAIL bp_load got %h %h want 55 66", ha, hb);
    end
    out_ready = 0;
    for (int i = 0; i < 4; i++) begin
      ReadData1 = $urandom; ReadData2 = $urandom;
      ALUSrc = 2'($urandom);
      #1;
      checks++;
      if (in_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_ready%0d got %b want 0", i, in_ready);
      end
      cycle();
      checks++;
      if (ALU1 !== 32'h55 || ALU2 !== 32'h66
          || out_valid !== 1'b1) begin
        errors++;
        $display("FAIL bp_hold%0d got %h %h v %b want 55 66 1",
                 i, ALU1, ALU2, out_valid);
      end
    end
    out_ready = 1; ALUSrc = 0;
    for (int i = 0; i < 3; i++) begin
      ReadData1 = 32'h100 + i; ReadData2 = 32'h200 + i;
      cycle();
      checks++;
      if (out_valid !== 1'b1 || ALU1 !== 32'h100 + i
          || ALU2 !== 32'h200 + i) begin
        errors++;
        $display("FAIL b2b%0d v %b got %h %h want 1 %h %h", i,
                 out_valid, ALU1, ALU2, 32'h100 + i, 32'h200 + i);
      end
    end
    in_valid = 0;
    cycle();
    checks++;
    if (out_valid !== 1'b0 || ALU1 !== 32'h102) begin
      errors++;
      $display("FAIL drain v %b a %h want 0 102", out_valid, ALU1);
    end
  endtask

  task automatic test_saturation();
    quiet();
    reset = 1;
    cycle();
    reset = 0; in_valid = 1; ExMemIsLoad = 1;
    ExMemRegWrite = 1; ExMemRd = 5; RtAddr = 5; ALUSrc = 0;
    repeat (10) cycle();
    checks++;
    if (StallCount !== 3'd7) begin
      errors++;
      $display("FAIL sat got %0d want 7", StallCount);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      rand_ops();
      reset     = ($urandom_range(0, 39) == 0);
      in_valid  = 1'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      ExMemIsLoad = ($urandom_range(0, 2) == 0);
      #1;
      checks++;
      if (HazardStall !== m_hz() || in_ready !== m_rdy()) begin
        errors++;
        $display("FAIL rnd_comb%0d hz %b rdy %b want %b %b", i,
                 HazardStall, in_ready, m_hz(), m_rdy());
      end
      cycle();
      checks++;
      if (out_valid !== m_valid || ALU1 !== m_a || ALU2 !== m_b
          || FwdA !== m_fa || FwdB !== m_fb
          || StallCount !== 3'(m_cnt)) begin
        errors++;
        $display("FAIL rnd%0d got v%b %h %h %b %b c%0d want v%b %h %h %b %b c%0d",
                 i, out_valid, ALU1, ALU2, FwdA, FwdB, StallCount,
                 m_valid, m_a, m_b, m_fa, m_fb, m_cnt);
      end
    end
  endtask

  initial begin
    quiet();
    @(negedge clk);
    test_reset();
    test_alusrc();
    test_forwarding();
    test_load_use();
    test_backpressure();
    test_saturation();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
